// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port (video/CPU) arbiter and sequencer for the SDRAM controller
//
// Purpose:
//   Shares one SDRAM controller between a read-only video fetch port
//   (priority) and a CPU read/write port. One transaction in flight at a time:
//   IDLE -> ISSUE -> WAIT -> DONE -> IDLE. Command fields are latched at grant.
//   A saturating streak counter lets the CPU in after MAX_VID_STREAK
//   consecutive video grants while the CPU is waiting.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   vid_req_i, vid_addr_i          video read request / word address
//   vid_ack_o, vid_rdata_o         video completion pulse / held read data
//   cpu_req_i, cpu_we_i            CPU request / write enable
//   cpu_addr_i, cpu_wdata_i,
//   cpu_wmask_i                    CPU command fields
//   cpu_ack_o, cpu_rdata_o         CPU completion pulse / held read data
//   sdram_rd_o, sdram_wr_o         one-cycle command strobes
//   sdram_addr_o, sdram_wdata_o,
//   sdram_wmask_o                  latched command fields (zero while idle)
//   sdram_rdata_i, sdram_ack_i     controller read data / completion pulse
//   sdram_rdy_i                    controller can accept a strobe
//   busy_o                         not in IDLE
//   err_o                          sticky: controller ack seen outside WAIT

module sdram_port_arbiter #(
  parameter int ADDR_W         = 24,
  parameter int MAX_VID_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vid_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic              vid_ack_o,
  output logic [15:0]       vid_rdata_o,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [15:0]       cpu_wdata_i,
  input  logic [1:0]        cpu_wmask_i,
  output logic              cpu_ack_o,
  output logic [15:0]       cpu_rdata_o,
  output logic              sdram_rd_o,
  output logic              sdram_wr_o,
  output logic [ADDR_W-1:0] sdram_addr_o,
  output logic [15:0]       sdram_wdata_o,
  output logic [1:0]        sdram_wmask_o,
  input  logic [15:0]       sdram_rdata_i,
  input  logic              sdram_ack_i,
  input  logic              sdram_rdy_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int STREAK_W = $clog2(MAX_VID_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VID_STREAK);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          r_state;
  logic                r_owner_cpu;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_wdata;
  logic [1:0]          r_wmask;
  logic [15:0]         r_vid_rdata;
  logic [15:0]         r_cpu_rdata;
  logic [STREAK_W-1:0] r_streak;
  logic                r_err;

  logic w_busy;
  logic w_grant;
  logic w_cpu_wins;

  assign w_busy     = (r_state != S_IDLE);
  assign w_grant    = (r_state == S_IDLE) && (vid_req_i || cpu_req_i) && sdram_rdy_i;
  // Video has priority unless the CPU has waited through a full streak.
  assign w_cpu_wins = cpu_req_i && ((r_streak == STREAK_MAX) || !vid_req_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_owner_cpu <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_vid_rdata <= '0;
      r_cpu_rdata <= '0;
      r_streak    <= '0;
      r_err       <= 1'b0;
    end else begin
      // A controller ack is only legal while waiting; anything else is flagged and dropped.
      if (sdram_ack_i && (r_state != S_WAIT)) begin
        r_err <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state <= S_ISSUE;
            if (w_cpu_wins) begin
              r_owner_cpu <= 1'b1;
              r_we        <= cpu_we_i;
              r_addr      <= cpu_addr_i;
              r_wdata     <= cpu_wdata_i;
              r_wmask     <= cpu_wmask_i;
              r_streak    <= '0;
            end else begin
              r_owner_cpu <= 1'b0;
              r_we        <= 1'b0;
              r_addr      <= vid_addr_i;
              r_wdata     <= '0;
              r_wmask     <= 2'b11;
              // Only video grants that actually make the CPU wait count toward the streak.
              if (!cpu_req_i) begin
                r_streak <= '0;
              end else if (r_streak != STREAK_MAX) begin
                r_streak <= r_streak + STREAK_W'(1);
              end
            end
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (sdram_ack_i) begin
            r_state <= S_DONE;
            if (!r_we) begin
              if (r_owner_cpu) r_cpu_rdata <= sdram_rdata_i;
              else             r_vid_rdata <= sdram_rdata_i;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = w_busy;
  assign err_o         = r_err;
  assign sdram_rd_o    = (r_state == S_ISSUE) && !r_we;
  assign sdram_wr_o    = (r_state == S_ISSUE) && r_we;
  // Command fields are only presented while a transaction is open, so idle outputs stay low.
  assign sdram_addr_o  = w_busy ? r_addr  : '0;
  assign sdram_wdata_o = w_busy ? r_wdata : '0;
  assign sdram_wmask_o = w_busy ? r_wmask : '0;
  assign vid_ack_o     = (r_state == S_DONE) && !r_owner_cpu;
  assign cpu_ack_o     = (r_state == S_DONE) && r_owner_cpu;
  assign vid_rdata_o   = r_vid_rdata;
  assign cpu_rdata_o   = r_cpu_rdata;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - self-checking bench for sdram_port_arbiter

module tb_sdram_port_arbiter;

  localparam int AW   = 24;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          vid_req_i;
  logic [AW-1:0] vid_addr_i;
  logic          vid_ack_o;
  logic [15:0]   vid_rdata_o;
  logic          cpu_req_i;
  logic          cpu_we_i;
  logic [AW-1:0] cpu_addr_i;
  logic [15:0]   cpu_wdata_i;
  logic [1:0]    cpu_wmask_i;
  logic          cpu_ack_o;
  logic [15:0]   cpu_rdata_o;
  logic          sdram_rd_o;
  logic          sdram_wr_o;
  logic [AW-1:0] sdram_addr_o;
  logic [15:0]   sdram_wdata_o;
  logic [1:0]    sdram_wmask_o;
  logic [15:0]   sdram_rdata_i;
  logic          sdram_ack_i;
  logic          sdram_rdy_i;
  logic          busy_o;
  logic          err_o;

  always #20 clk = ~clk;

  sdram_port_arbiter #(.ADDR_W(AW), .MAX_VID_STREAK(MAXS)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .vid_req_i(vid_req_i), .vid_addr_i(vid_addr_i),
    .vid_ack_o(vid_ack_o), .vid_rdata_o(vid_rdata_o),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_wmask_i(cpu_wmask_i),
    .cpu_ack_o(cpu_ack_o), .cpu_rdata_o(cpu_rdata_o),
    .sdram_rd_o(sdram_rd_o), .sdram_wr_o(sdram_wr_o),
    .sdram_addr_o(sdram_addr_o), .sdram_wdata_o(sdram_wdata_o),
    .sdram_wmask_o(sdram_wmask_o), .sdram_rdata_i(sdram_rdata_i),
    .sdram_ack_i(sdram_ack_i), .sdram_rdy_i(sdram_rdy_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_rd    = 0;
  int n_wr    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction-level model: a transaction is granted at clock edge m_g; the
  // strobe is visible in the cycle following that edge, the controller ack is
  // accepted at edge m_a >= m_g+2, the port ack is visible in the cycle after
  // m_a, and the transaction closes at edge m_a+1.
  int            cyc = 0;
  bit            m_open = 0;
  int            m_g = 0;
  int            m_a = -1;
  bit            m_cpu = 0;
  bit            m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [15:0]   m_wdata = '0;
  logic [1:0]    m_wmask = '0;
  logic [15:0]   m_vrd = '0;
  logic [15:0]   m_crd = '0;
  bit            m_err = 0;
  int            m_streak = 0;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_open = 0; m_a = -1; m_vrd = '0; m_crd = '0; m_err = 0; m_streak = 0;
    end else begin
      cyc = cyc + 1;
      if (m_open && m_a >= 0) begin
        if (sdram_ack_i) m_err = 1;
        m_open = 0;
      end else if (m_open) begin
        if (sdram_ack_i) begin
          if (cyc >= m_g + 2) begin
            m_a = cyc;
            if (!m_we) begin
              if (m_cpu) m_crd = sdram_rdata_i;
              else       m_vrd = sdram_rdata_i;
            end
          end else begin
            m_err = 1;
          end
        end
      end else begin
        if (sdram_ack_i) m_err = 1;
        if ((vid_req_i || cpu_req_i) && sdram_rdy_i) begin
          m_open = 1; m_g = cyc; m_a = -1;
          if (cpu_req_i && (m_streak == MAXS || !vid_req_i)) begin
            m_cpu = 1; m_we = cpu_we_i; m_addr = cpu_addr_i;
            m_wdata = cpu_wdata_i; m_wmask = cpu_wmask_i; m_streak = 0;
          end else begin
            m_cpu = 0; m_we = 0; m_addr = vid_addr_i; m_wdata = '0; m_wmask = 2'b11;
            m_streak = cpu_req_i ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sdram_rd_o) n_rd++;
      if (sdram_wr_o) n_wr++;
      chk("busy",      busy_o,      m_open);
      chk("rd_strobe", sdram_rd_o,  m_open && cyc == m_g && !m_we);
      chk("wr_strobe", sdram_wr_o,  m_open && cyc == m_g && m_we);
      chk("vid_ack",   vid_ack_o,   m_open && m_a >= 0 && !m_cpu);
      chk("cpu_ack",   cpu_ack_o,   m_open && m_a >= 0 && m_cpu);
      chk("vid_rdata", vid_rdata_o, m_vrd);
      chk("cpu_rdata", cpu_rdata_o, m_crd);
      chk("err",       err_o,       m_err);
      chk("addr",      sdram_addr_o,  m_open ? m_addr  : '0);
      chk("wdata",     sdram_wdata_o, m_open ? m_wdata : '0);
      chk("wmask",     sdram_wmask_o, m_open ? m_wmask : '0);
    end
  end

  logic [AW-1:0] s_addr;
  logic [15:0]   s_wdata;
  logic [1:0]    s_wmask;

  task automatic wait_strobe(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sdram_rd_o || sdram_wr_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("strobe_timeout", ok, 1);
    s_addr = sdram_addr_o; s_wdata = sdram_wdata_o; s_wmask = sdram_wmask_o;
  endtask

  // Waits for a strobe, raises the controller ack `lat` cycles later, and
  // returns at the falling edge inside the port-ack cycle.
  task automatic serve(input int lat, input logic [15:0] rd);
    bit ok;
    wait_strobe(ok);
    repeat (lat) @(negedge clk);
    sdram_rdata_i = rd; sdram_ack_i = 1'b1;
    @(negedge clk);
    sdram_rdata_i = '0; sdram_ack_i = 1'b0;
  endtask

  string seq;
  string exp_seq;
  int    k0;

  initial begin
    rst_ni = 1'b0; vid_req_i = 0; vid_addr_i = '0; cpu_req_i = 0; cpu_we_i = 0;
    cpu_addr_i = '0; cpu_wdata_i = '0; cpu_wmask_i = '0;
    sdram_rdata_i = '0; sdram_ack_i = 0; sdram_rdy_i = 1;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy_o, 0);
    chk("reset_err", err_o, 0);
    chk("reset_rdata", {vid_rdata_o, cpu_rdata_o}, 0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    // single CPU write
    k0 = n_wr;
    cpu_req_i = 1; cpu_we_i = 1; cpu_addr_i = 24'h000010; cpu_wdata_i = 16'hBEEF; cpu_wmask_i = 2'b01;
    serve(3, 16'h0000);
    chk("w_addr", s_addr, 24'h000010);
    chk("w_wdata", s_wdata, 16'hBEEF);
    chk("w_wmask", s_wmask, 2'b01);
    chk("w_cpu_ack", cpu_ack_o, 1);
    chk("w_vid_ack", vid_ack_o, 0);
    cpu_req_i = 0; cpu_we_i = 0;
    repeat (2) @(negedge clk);
    chk("w_one_strobe", n_wr - k0, 1);
    chk("w_rdata_kept", cpu_rdata_o, 16'h0000);

    // video read
    vid_req_i = 1; vid_addr_i = 24'h123456;
    serve(2, 16'hA5A5);
    chk("v_addr", s_addr, 24'h123456);
    chk("v_wmask", s_wmask, 2'b11);
    chk("v_ack", vid_ack_o, 1);
    chk("v_rdata", vid_rdata_o, 16'hA5A5);
    chk("v_cpu_rdata", cpu_rdata_o, 16'h0000);
    vid_req_i = 0;
    repeat (2) @(negedge clk);

    // CPU read
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 24'h000020;
    serve(1, 16'h1234);
    chk("r_cpu_rdata", cpu_rdata_o, 16'h1234);
    chk("r_vid_rdata", vid_rdata_o, 16'hA5A5);
    cpu_req_i = 0;
    repeat (2) @(negedge clk);

    // starvation bound
    seq = "";
    exp_seq = "VVVVCVVVVC";
    vid_req_i = 1; vid_addr_i = 24'h000100;
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 24'h000200;
    for (int i = 0; i < 10; i++) begin
      serve(1, 16'(i + 1));
      seq = {seq, (s_addr == 24'h000200) ? "C" : "V"};
    end
    vid_req_i = 0; cpu_req_i = 0;
    for (int i = 0; i < 10; i++) chk($sformatf("grant_%0d", i), seq[i], exp_seq[i]);
    repeat (2) @(negedge clk);

    // controller not ready
    sdram_rdy_i = 0; vid_req_i = 1; vid_addr_i = 24'h000055;
    k0 = n_rd + n_wr;
    repeat (10) @(negedge clk);
    chk("nr_no_strobe", n_rd + n_wr - k0, 0);
    chk("nr_busy", busy_o, 0);
    sdram_rdy_i = 1;
    @(negedge clk);
    chk("nr_strobe_next", sdram_rd_o, 1);
    @(negedge clk);
    sdram_rdata_i = 16'h0F0F; sdram_ack_i = 1;
    @(negedge clk);
    sdram_rdata_i = '0; sdram_ack_i = 0;
    chk("nr_vid_ack", vid_ack_o, 1);
    vid_req_i = 0;
    repeat (2) @(negedge clk);

    // spurious ack in IDLE
    sdram_ack_i = 1;
    @(negedge clk);
    sdram_ack_i = 0;
    chk("sp_err", err_o, 1);
    chk("sp_acks", {vid_ack_o, cpu_ack_o}, 0);
    repeat (4) @(negedge clk);
    chk("sp_err_sticky", err_o, 1);

    // async reset during WAIT
    begin
      bit ok;
      cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 24'h000300;
      wait_strobe(ok);
      @(negedge clk);
      chk("rst_in_wait", busy_o, 1);
      #5 rst_ni = 0;
      #1;
      chk("rst_busy", busy_o, 0);
      chk("rst_strobes", {sdram_rd_o, sdram_wr_o}, 0);
      chk("rst_acks", {vid_ack_o, cpu_ack_o}, 0);
      chk("rst_fields", {sdram_addr_o, sdram_wdata_o, sdram_wmask_o}, 0);
      chk("rst_err", err_o, 0);
      chk("rst_rdata", {vid_rdata_o, cpu_rdata_o}, 0);
      cpu_req_i = 0;
      @(negedge clk);
      rst_ni = 1;
      repeat (2) @(negedge clk);
      sdram_rdata_i = 16'hDEAD; sdram_ack_i = 1;
      @(negedge clk);
      sdram_rdata_i = '0; sdram_ack_i = 0;
      chk("late_err", err_o, 1);
      chk("late_acks", {vid_ack_o, cpu_ack_o}, 0);
      chk("late_rdata", cpu_rdata_o, 16'h0000);
      repeat (3) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
